// File: rtl/fullsend_mem_pkg.sv
// Shared types for the data-memory responder: FSM states, access direction, word type.
package fullsend_mem_pkg;
    typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} mem_resp_state_t;
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/data_sram.sv
// Single-port synchronous word array, read-first, one-cycle registered read, no reset.
module data_sram
    import fullsend_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  word_t            wdata,
    output word_t            rdata
);
    word_t mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request, waits LATENCY cycles, then pulses mem_ready
// with read data or an error flag. Array contents survive reset.
module data_mem_responder
    import fullsend_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  mem_enable,
    input  logic  mem_r_w,
    input  word_t mem_address,
    input  word_t mem_input,
    output word_t mem_output,
    output logic  mem_ready,
    output logic  mem_error,
    output logic  mem_busy
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end

    mem_resp_state_t  state;
    logic [3:0]       cnt;
    word_t            lat_addr;
    word_t            lat_data;
    logic             lat_wr;
    logic             rd_valid;
    word_t            rdata;

    // While idle the incoming request is decoded directly so a LATENCY=1 read
    // can be issued to the array in its accept cycle.
    word_t            cur_addr;
    word_t            cur_off;
    logic             cur_wr;
    logic             cur_err;
    logic [IDX_W-1:0] cur_idx;
    logic             sram_we;

    assign cur_addr = (state == MR_IDLE) ? mem_address : lat_addr;
    assign cur_wr   = (state == MR_IDLE) ? mem_r_w : lat_wr;
    assign cur_off  = cur_addr - BASE_ADDR;
    assign cur_err  = (cur_addr[1:0] != 2'b00) || (cur_off >= SPAN);
    assign cur_idx  = cur_off[IDX_W+1:2];
    assign sram_we  = (state == MR_RESP) && (lat_wr == MEM_WRITE) && !cur_err;

    data_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_sram (
        .clk  (clk),
        .we   (sram_we),
        .idx  (cur_idx),
        .wdata(lat_data),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (state == MR_IDLE && mem_enable) begin
            lat_addr <= mem_address;
            lat_data <= mem_input;
            lat_wr   <= mem_r_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= MR_IDLE;
            cnt       <= 4'd0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            mem_busy  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                MR_IDLE: begin
                    if (mem_enable) begin
                        cnt      <= CNT_INIT;
                        mem_busy <= 1'b1;
                        if (LATENCY == 1) begin
                            state     <= MR_RESP;
                            mem_ready <= 1'b1;
                            mem_error <= cur_err;
                            rd_valid  <= (cur_wr == MEM_READ) && !cur_err;
                        end else begin
                            state <= MR_WAIT;
                        end
                    end
                end
                MR_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= MR_RESP;
                        mem_ready <= 1'b1;
                        mem_error <= cur_err;
                        rd_valid  <= (cur_wr == MEM_READ) && !cur_err;
                    end
                end
                MR_RESP: begin
                    state    <= MR_IDLE;
                    mem_busy <= 1'b0;
                end
                default: state <= MR_IDLE;
            endcase
        end
    end

    // Both operands are registers, so the gated output carries no decode glitches.
    assign mem_output = rd_valid ? rdata : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2, 3, 1) checked against a word-array model.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        en   [3];
    logic        rw   [3];
    logic [31:0] addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        err  [3];
    logic        busy [3];

    logic [31:0] model_mem [3][64];
    bit          known     [3][64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDR(32'h0)) u_lat2 (
        .clk(clk), .reset(reset), .mem_enable(en[0]), .mem_r_w(rw[0]), .mem_address(addr[0]),
        .mem_input(din[0]), .mem_output(dout[0]), .mem_ready(rdy[0]), .mem_error(err[0]),
        .mem_busy(busy[0]));
    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(3), .BASE_ADDR(32'h400)) u_lat3 (
        .clk(clk), .reset(reset), .mem_enable(en[1]), .mem_r_w(rw[1]), .mem_address(addr[1]),
        .mem_input(din[1]), .mem_output(dout[1]), .mem_ready(rdy[1]), .mem_error(err[1]),
        .mem_busy(busy[1]));
    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h0)) u_lat1 (
        .clk(clk), .reset(reset), .mem_enable(en[2]), .mem_r_w(rw[2]), .mem_address(addr[2]),
        .mem_input(din[2]), .mem_output(dout[2]), .mem_ready(rdy[2]), .mem_error(err[2]),
        .mem_busy(busy[2]));

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 1) ? 32'h400 : 32'h0;
    endfunction

    // One complete request on instance k; response expected LATENCY edges after accept (accept edge counts as 1).
    task automatic txn(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        int          lat;
        int          idx;
        logic [31:0] off;
        logic        exp_err;
        lat     = lat_of(k);
        off     = a - base_of(k);
        exp_err = (a[1:0] != 2'b00) || (off >= 32'd256);
        idx     = int'(off[7:2]);
        @(negedge clk);
        en[k] = 1'b1; rw[k] = wr; addr[k] = a; din[k] = d;
        @(posedge clk); #1;
        en[k] = 1'b0; rw[k] = 1'($urandom); addr[k] = $urandom; din[k] = $urandom;
        checks++;
        if (busy[k] !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_accept k%0d got %b want 1", tag, k, busy[k]);
        end
        for (int j = 1; j <= lat; j++) begin
            if (j > 1) begin
                @(posedge clk); #1;
            end
            checks++;
            if (rdy[k] !== (j == lat)) begin
                errors++;
                $display("FAIL %s ready_timing k%0d edge %0d got %b want %b", tag, k, j, rdy[k], j == lat);
            end
        end
        checks++;
        if (err[k] !== exp_err) begin
            errors++; $display("FAIL %s error_flag k%0d got %b want %b", tag, k, err[k], exp_err);
        end
        if (wr || exp_err) begin
            checks++;
            if (dout[k] !== 32'h0) begin
                errors++; $display("FAIL %s output_zero k%0d got %h want 00000000", tag, k, dout[k]);
            end
        end else if (known[k][idx]) begin
            checks++;
            if (dout[k] !== model_mem[k][idx]) begin
                errors++;
                $display("FAIL %s read_data k%0d got %h want %h", tag, k, dout[k], model_mem[k][idx]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (rdy[k] !== 1'b0 || busy[k] !== 1'b0 || err[k] !== 1'b0 || dout[k] !== 32'h0) begin
            errors++;
            $display("FAIL %s back_to_idle k%0d got rdy=%b busy=%b err=%b out=%h want 0 0 0 0",
                     tag, k, rdy[k], busy[k], err[k], dout[k]);
        end
        if (wr && !exp_err) begin
            model_mem[k][idx] = d;
            known[k][idx]     = 1'b1;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; din[k] = '0;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0 || dout[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state k%0d got rdy=%b err=%b busy=%b out=%h want 0 0 0 0",
                         k, rdy[k], err[k], busy[k], dout[k]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        txn(0, 1'b0, 32'h10, $urandom, "rd10");
    endtask

    task automatic test_errors();
        txn(0, 1'b0, 32'h13, 32'h0, "rd_misaligned");
        txn(0, 1'b0, 32'h100, 32'h0, "rd_out_of_range");
        txn(0, 1'b1, 32'h13, 32'hCAFEF00D, "wr_misaligned");
        txn(0, 1'b0, 32'h10, 32'h0, "rd10_unchanged");
        txn(1, 1'b0, 32'h0, 32'h0, "rd_below_base");
        txn(1, 1'b1, 32'h404, 32'h0BADF00D, "wr_base_plus4");
        txn(1, 1'b0, 32'h404, 32'h0, "rd_base_plus4");
        txn(1, 1'b0, 32'h500, 32'h0, "rd_base_end");
    endtask

    task automatic test_back_to_back();
        int          next_free = 0;
        int          resp_at   = -1;
        int          pulses    = 0;
        logic [31:0] last      = '0;
        logic [31:0] d0        = $urandom;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            en[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h410; din[1] = d0 + 32'(c);
            @(posedge clk); #1;
            if (c == next_free) begin
                last      = d0 + 32'(c);
                resp_at   = c + lat_of(1) - 1;
                next_free = c + lat_of(1) + 1;
            end
            if (rdy[1] === 1'b1) pulses++;
            checks++;
            if (rdy[1] !== (c == resp_at) || err[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d got rdy=%b err=%b want rdy=%b err=0",
                         c, rdy[1], err[1], c == resp_at);
            end
            @(negedge clk);
        end
        en[1] = 1'b0;
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL b2b_pulse_count got %0d want 4", pulses);
        end
        model_mem[1][4] = last;
        known[1][4]     = 1'b1;
        txn(1, 1'b0, 32'h410, 32'h0, "b2b_readback");
    endtask

    task automatic test_latency1();
        txn(2, 1'b1, 32'h0, 32'h1234, "lat1_wr0");
        txn(2, 1'b0, 32'h0, 32'h0, "lat1_rd0");
        txn(2, 1'b0, 32'h2, 32'h0, "lat1_misaligned");
    endtask

    task automatic test_reset_midflight();
        // Reset during WAIT, request strobe still high.
        txn(0, 1'b1, 32'h20, 32'h11112222, "old20");
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'hA5A5A5A5;
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL wait_busy got %b want 1", busy[0]);
        end
        #1 reset = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (rdy[0] !== 1'b0 || err[0] !== 1'b0 || busy[0] !== 1'b0 || dout[0] !== 32'h0) begin
                errors++;
                $display("FAIL reset_in_wait step %0d got rdy=%b err=%b busy=%b out=%h want 0 0 0 0",
                         n, rdy[0], err[0], busy[0], dout[0]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        en[0] = 1'b0; reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            checks++;
            if (rdy[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL no_resp_after_reset cycle %0d got rdy=%b busy=%b want 0 0", n, rdy[0], busy[0]);
            end
        end
        txn(0, 1'b0, 32'h20, 32'h0, "rd20_old");

        // Reset during RESP of a write: the commit edge never arrives.
        txn(0, 1'b1, 32'h24, 32'h33334444, "old24");
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; addr[0] = 32'h24; din[0] = 32'h5A5A5A5A;
        @(posedge clk); #1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++; $display("FAIL resp_before_reset got %b want 1", rdy[0]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rdy[0] !== 1'b0 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_resp got rdy=%b busy=%b err=%b want 0 0 0", rdy[0], busy[0], err[0]);
        end
        @(negedge clk);
        reset = 1'b1;
        txn(0, 1'b0, 32'h24, 32'h0, "rd24_old");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 20; n++) begin
                logic [31:0] a;
                if ($urandom_range(0, 7) == 0) a = $urandom;
                else a = base_of(k) + 32'(4 * $urandom_range(0, 15));
                txn(k, 1'($urandom), a, $urandom, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_back_to_back();
        test_latency1();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
